// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its RAM array.
package data_mem_responder_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned NUM_LANES   = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned ADDR_LSB    = 2;
    localparam int unsigned MAX_LATENCY = 15;
    localparam int unsigned CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic                 we;
        logic [WIDTH-1:0]     addr;
        logic [WIDTH-1:0]     wdata;
        logic [NUM_LANES-1:0] wstrb;
    } req_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0]     old_w,
                                                    input logic [WIDTH-1:0]     new_w,
                                                    input logic [NUM_LANES-1:0] strb);
        logic [WIDTH-1:0] merged;
        merged = old_w;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (strb[i]) merged[BYTE_W*i +: BYTE_W] = new_w[BYTE_W*i +: BYTE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel bundle between a memory master and the responder.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [WIDTH-1:0]     req_addr;
    logic [WIDTH-1:0]     req_wdata;
    logic [NUM_LANES-1:0] req_wstrb;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WIDTH-1:0]     rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_ram_array.sv
// Word RAM with byte-strobed synchronous write and combinational read on one index.
module dmem_ram_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [NUM_LANES-1:0]           wstrb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata_c
);

    logic [WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [WIDTH-1:0] wr_word_d;

    always_comb begin
        rdata_c   = mem_q[idx];
        wr_word_d = lane_merge(mem_q[idx], wdata, wstrb);
    end

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wr_word_d;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Slow-memory responder: accepts one word request, waits LATENCY cycles, then
// performs the access and holds the response until the master takes it.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned      DEPTH_WORDS = 64,
    parameter int unsigned      LATENCY     = 2,
    parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned      IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [WIDTH-1:0] SPAN_BYTES = WIDTH'(DEPTH_WORDS * NUM_LANES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [WIDTH-1:0] offset;
    logic             acc_err;
    logic             access;
    logic             ram_we;
    logic [IDX_W-1:0] ram_idx;
    logic [WIDTH-1:0] ram_rdata;

    // Address check on the latched request; wrap below BASE_ADDR lands out of range.
    always_comb begin
        offset  = req_q.addr - BASE_ADDR;
        acc_err = (req_q.addr[ADDR_LSB-1:0] != '0) || (offset >= SPAN_BYTES);
        ram_idx = offset[ADDR_LSB +: IDX_W];
        access  = (state_q == ST_WAIT) && (cnt_q == '0);
        ram_we  = access && req_q.we && !acc_err;
    end

    dmem_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wstrb   (req_q.wstrb),
        .idx     (ram_idx),
        .wdata   (req_q.wdata),
        .rdata_c (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d.we    = bus.req_we;
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                    req_d.wstrb = bus.req_wstrb;
                    cnt_d       = CNT_W'(LATENCY);
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (!req_q.we && !acc_err) ? ram_rdata : '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=2 at base 0, LATENCY=0 at base 0x1000).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if if2 ();
    data_mem_responder_if if0 ();

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2), .BASE_ADDR(32'h0000_0000))
        u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(0), .BASE_ADDR(32'h0000_1000))
        u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t cur[2];
    bit   seen[2];
    bit   hs_pend[2];

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned last_acc0 = 0;
    bit          have_last0 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic f_req_ready(input int s);
        return (s == 0) ? if0.req_ready : if2.req_ready;
    endfunction
    function automatic logic f_rsp_valid(input int s);
        return (s == 0) ? if0.rsp_valid : if2.rsp_valid;
    endfunction
    function automatic logic f_rsp_ready(input int s);
        return (s == 0) ? if0.rsp_ready : if2.rsp_ready;
    endfunction
    function automatic logic f_rsp_err(input int s);
        return (s == 0) ? if0.rsp_err : if2.rsp_err;
    endfunction
    function automatic logic [31:0] f_rsp_rdata(input int s);
        return (s == 0) ? if0.rsp_rdata : if2.rsp_rdata;
    endfunction

    task automatic drv(input int s, input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
        if (s == 0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_addr = addr;
            if0.req_wdata = wdata; if0.req_wstrb = strb;
        end else begin
            if2.req_valid = v; if2.req_we = we; if2.req_addr = addr;
            if2.req_wdata = wdata; if2.req_wstrb = strb;
        end
    endtask

    // Present a request, wait for acceptance, and queue the expected response.
    task automatic issue(input int s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input bit push, input bit hold);
        int          waited = 0;
        int unsigned acc;
        exp_t        e;
        @(negedge clk);
        drv(s, 1'b1, we, addr, wdata, strb);
        while (!f_req_ready(s)) begin
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                chk($sformatf("accept_timeout%0d", s), 32'd0, 32'd1);
                drv(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
                return;
            end
        end
        acc = cyc + 1;
        if (s == 0) begin
            if (have_last0) chk("accept_spacing0", acc - last_acc0, 32'd3);
            last_acc0  = acc;
            have_last0 = 1'b1;
        end
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = acc + 1 + ((s == 0) ? 0 : 2);
            if (s == 0) q0.push_back(e); else q2.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) drv(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic mon_step(input int s);
        if (hs_pend[s]) begin
            chk($sformatf("req_ready_after_hs%0d", s), 32'(f_req_ready(s)), 32'd1);
            hs_pend[s] = 1'b0;
        end
        if (f_rsp_valid(s)) begin
            if (!seen[s]) begin
                if ((s == 0 ? q0.size() : q2.size()) == 0) begin
                    chk($sformatf("unexpected_rsp%0d", s), 32'd1, 32'd0);
                    cur[s] = '{32'd0, 1'b0, 0};
                end else begin
                    cur[s] = (s == 0) ? q0.pop_front() : q2.pop_front();
                    chk($sformatf("rsp_latency%0d", s), cyc, cur[s].cyc);
                end
                seen[s] = 1'b1;
            end
            chk($sformatf("busy_req_ready%0d", s), 32'(f_req_ready(s)), 32'd0);
            chk($sformatf("rsp_rdata%0d", s), f_rsp_rdata(s), cur[s].rdata);
            chk($sformatf("rsp_err%0d", s), 32'(f_rsp_err(s)), 32'(cur[s].err));
            if (f_rsp_ready(s)) begin
                seen[s]    = 1'b0;
                hs_pend[s] = 1'b1;
            end
        end else begin
            seen[s] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            seen    = '{1'b0, 1'b0};
            hs_pend = '{1'b0, 1'b0};
        end else begin
            for (int s = 0; s < 2; s++) mon_step(s);
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (q0.size() != 0 || q2.size() != 0 || if0.rsp_valid || if2.rsp_valid) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("drain_timeout", 32'd0, 32'd1);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid2"}, 32'(if2.rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata2"}, if2.rsp_rdata, 32'd0);
        chk({tag, "_rsp_err2"},   32'(if2.rsp_err), 32'd0);
        chk({tag, "_req_ready2"}, 32'(if2.req_ready), 32'd1);
        chk({tag, "_rsp_valid0"}, 32'(if0.rsp_valid), 32'd0);
        chk({tag, "_req_ready0"}, 32'(if0.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drv(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drv(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        if0.rsp_ready = 1'b1;
        if2.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;

        // Store then load, full word.
        issue(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(2, 1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        // Byte strobes.
        issue(2, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(2, 1'b1, 32'h10, 32'h5500_0000, 4'b1000, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(2, 1'b0, 32'h10, 32'h0,         4'h0, 32'h55AD_BEAA, 1'b0, 1'b1, 1'b0);
        // Errors, last word, no-op store.
        issue(2, 1'b0, 32'h12,  32'h0,         4'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        issue(2, 1'b1, 32'h0,   32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(2, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0);
        issue(2, 1'b1, 32'h0,   32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(2, 1'b0, 32'h0,   32'h0,         4'h0, 32'h1122_3344, 1'b0, 1'b1, 1'b0);
        issue(2, 1'b1, 32'hFC,  32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(2, 1'b0, 32'hFC,  32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // Response backpressure for 5 cycles.
        @(posedge clk); #1;
        if2.rsp_ready = 1'b0;
        issue(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'h55AD_BEAA, 1'b0, 1'b1, 1'b0);
        begin
            int n = 0;
            while (!if2.rsp_valid && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) chk("bp_rsp_timeout", 32'd0, 32'd1);
        end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        if2.rsp_ready = 1'b1;
        wait_drain();

        // LATENCY=0 back-to-back with continuous req_valid.
        issue(0, 1'b1, 32'h1000, 32'h0102_0304, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1);
        issue(0, 1'b1, 32'h10FC, 32'hA0B0_C0D0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h1000, 32'h0,         4'h0, 32'h0102_0304, 1'b0, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h10FC, 32'h0,         4'h0, 32'hA0B0_C0D0, 1'b0, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h0FFC, 32'h0,         4'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        issue(0, 1'b1, 32'h1100, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h1002, 32'h0,         4'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        have_last0 = 1'b0;
        wait_drain();

        // Reset in the middle of WAIT aborts a store.
        issue(2, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0);
        wait_drain();
        issue(2, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(2, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the core's data-memory port. A load/store unit or bus master issues word requests over a valid/ready request channel. This block services them from an internal word-addressed RAM after a programmable number of wait states. It returns read data and an error flag over a valid/ready response channel. It lets the datapath be tested against a slow memory that applies backpressure, instead of an ideal single-cycle array.

Parameters:
WIDTH, 32, data and address width in bits; fixed at 32 (4 byte lanes).
DEPTH_WORDS, 64, number of words in the RAM; power of two.
LATENCY, 2, number of wait cycles between acceptance and the access; 0 to 15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  WIDTH  byte address.
req_wdata  input  WIDTH  store data.
req_wstrb  input  4  byte-lane write enables; bit i covers bits [8i+7:8i].
rsp_valid  output  1  response present.
rsp_ready  input  1  master accepts the response.
rsp_rdata  output  WIDTH  load data; 0 for stores and errors.
rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE, wait counter goes to 0, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not cleared.
- A reset during WAIT aborts the pending request. No RAM write occurs.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1: latch we, addr, wdata and wstrb; load counter with LATENCY; go to WAIT.
  - WAIT: req_ready=0. If counter is nonzero, decrement it. When counter=0, the next edge performs the access and moves to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready=1 on a rising edge. On that edge go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Latency: acceptance at edge t means rsp_valid rises at edge t+1+LATENCY. With LATENCY=0 the response is valid one cycle after acceptance.
- Throughput is one outstanding request. The earliest next acceptance is the cycle after the response handshake. No request is accepted while in RESP, even if rsp_ready=1.
- Access check, on the latched address:
  - Error if addr[1:0] != 0.
  - Error if (addr - BASE_ADDR) >= DEPTH_WORDS*4, using unsigned 32-bit subtraction, so addresses below BASE_ADDR wrap and also error.
  - Word index is (addr - BASE_ADDR) >> 2.
- Error access: no RAM write, rsp_rdata=0, rsp_err=1.
- Valid load: rsp_rdata = RAM[index], rsp_err=0.
- Valid store: update only the lanes whose strobe is 1. rsp_rdata=0, rsp_err=0. req_wstrb=0 is a legal no-op store.
- The RAM write and read-data capture happen on the same edge (WAIT to RESP).
- Request inputs are ignored outside IDLE. A master changing req_* while req_ready=0 has no effect.
- req_ready is a pure function of state (Moore output). There is no combinational path from rsp_ready to req_ready.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WAIT, RESP),
  - localparam NUM_LANES=4,
  - localparam ADDR_LSB=2,
  - the counter width derived from LATENCY (4 bits).
- One sub-module, dmem_ram_array: synchronous-write RAM with byte strobes and a combinational read, sized by DEPTH_WORDS. It is instantiated once.
- The FSM, address check and response registers stay in data_mem_responder.

Test Plan:
1. Basic store then load (LATENCY=2): store addr 0x10, data 0xDEADBEEF, strb 4'hF, then load 0x10 → store response err=0, rdata=0; load rdata=0xDEADBEEF. Each rsp_valid rises exactly 3 cycles after acceptance.
2. Byte strobes: after test 1, store 0x10 data 0x000000AA strb 4'b0001, then store data 0x55000000 strb 4'b1000, then load 0x10 → 0x55ADBEAA.
3. Errors:
   - load 0x12 → err=1, rdata=0.
   - store 0x100 with DEPTH_WORDS=64 → err=1; a later load of 0x0 returns its prior value unchanged.
4. Response backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rdata and err stay stable and req_ready=0 throughout. After the rsp_ready handshake, req_ready=1 on the next cycle.
5. LATENCY=0 back-to-back: continuous req_valid with rsp_ready=1 → one accept every 3 cycles; each response one cycle after its acceptance.
6. Reset mid-WAIT: store 0x20 data 0x12345678, then assert reset during WAIT → outputs go to 0 immediately without a clock edge, and state is IDLE. After release, load 0x20 returns its pre-store value.
